// File: rtl/fetch_unit.sv
// fetch_unit: issues PC-driven instruction fetches and presents them to decode on a valid/ready instruction register
module fetch_unit #(
    parameter int AW = 8,
    parameter int IW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc_addr,
    output logic          pc_inc,
    output logic          pc_jmp,
    output logic [AW-1:0] pc_addrin,
    output logic          imem_en,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_data,
    input  logic          halt,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_addr,
    output logic          ir_valid,
    output logic [IW-1:0] ir_data,
    output logic [AW-1:0] ir_pc,
    input  logic          ir_ready
);
    typedef enum logic [1:0] {ISSUE, CAPTURE, HOLD} state_t;
    state_t        state;
    logic          valid;
    logic          fetch;
    logic [AW-1:0] req_pc;
    assign fetch     = ~rst & ~halt & ~redirect & (state == ISSUE);
    assign pc_inc    = fetch;
    assign imem_en   = fetch;
    assign imem_addr = fetch ? pc_addr : '0;
    assign pc_jmp    = ~rst & redirect;
    assign pc_addrin = pc_jmp ? redirect_addr : '0;
    assign ir_valid  = valid & ~redirect;
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ISSUE;
            valid   <= 1'b0;
            req_pc  <= '0;
            ir_data <= '0;
            ir_pc   <= '0;
        end else if (redirect) begin
            state <= ISSUE;
            valid <= 1'b0;
        end else begin
            case (state)
                ISSUE: if (!halt) begin
                    req_pc <= pc_addr;
                    state  <= CAPTURE;
                end
                CAPTURE: begin
                    ir_data <= imem_data;
                    ir_pc   <= req_pc;
                    valid   <= 1'b1;
                    state   <= HOLD;
                end
                HOLD: if (valid && ir_ready) begin
                    valid <= 1'b0;
                    state <= ISSUE;
                end
                default: state <= ISSUE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a PC register and synchronous memory holding 0xA000+addr
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  pc_addr;
    logic        pc_inc, pc_jmp, imem_en, ir_valid;
    logic [7:0]  pc_addrin, imem_addr, ir_pc;
    logic [15:0] imem_data = 16'h0;
    logic [15:0] ir_data;
    logic        halt = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_addr = 8'h0;
    logic        ir_ready = 1'b1;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [7:0]  wrap_pc [3] = '{8'hFF, 8'h00, 8'h01};

    fetch_unit #(.AW(8), .IW(16)) dut (
        .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_inc(pc_inc), .pc_jmp(pc_jmp),
        .pc_addrin(pc_addrin), .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
        .halt(halt), .redirect(redirect), .redirect_addr(redirect_addr), .ir_valid(ir_valid),
        .ir_data(ir_data), .ir_pc(ir_pc), .ir_ready(ir_ready)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (rst) pc_addr <= 8'h00;
        else if (pc_jmp) pc_addr <= pc_addrin;
        else if (pc_inc) pc_addr <= pc_addr + 8'd1;
    end

    always_ff @(posedge clk) if (imem_en) imem_data <= 16'hA000 + {8'h00, imem_addr};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic h);
        rst = 1'b1;
        halt = h;
        redirect = 1'b0;
        ir_ready = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        do_reset(1'b0);
        rst = 1'b1;
        #1;
        chk("rst_valid", 32'(ir_valid), 32'h0);
        chk("rst_inc", 32'(pc_inc), 32'h0);
        chk("rst_jmp", 32'(pc_jmp), 32'h0);
        chk("rst_en", 32'(imem_en), 32'h0);
        chk("rst_data", 32'(ir_data), 32'h0);
        chk("rst_pc", 32'(ir_pc), 32'h0);
        chk("rst_addrin", 32'(pc_addrin), 32'h0);
        chk("rst_iaddr", 32'(imem_addr), 32'h0);

        do_reset(1'b0);
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) cyc();
            #1;
            chk("t1_inc", 32'(pc_inc), 32'(c % 3 == 0));
            chk("t1_valid", 32'(ir_valid), 32'(c % 3 == 2));
            chk("t1_jmp", 32'(pc_jmp), 32'h0);
            if (c % 3 == 0) chk("t1_iaddr", 32'(imem_addr), 32'(c / 3));
            if (c % 3 == 2) begin
                chk("t1_data", 32'(ir_data), 32'hA000 + 32'(c / 3));
                chk("t1_pc", 32'(ir_pc), 32'(c / 3));
            end
        end

        do_reset(1'b0);
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) cyc();
            ir_ready = !(c >= 2 && c <= 6);
            #1;
            chk("t2_en", 32'(imem_en), 32'(c == 0 || c == 8));
            chk("t2_inc", 32'(pc_inc), 32'(c == 0 || c == 8));
            chk("t2_valid", 32'(ir_valid), 32'((c >= 2 && c <= 7) || c == 10));
            if (c >= 2 && c <= 7) begin
                chk("t2_hold_data", 32'(ir_data), 32'hA000);
                chk("t2_hold_pc", 32'(ir_pc), 32'h00);
            end
            if (c == 10) begin
                chk("t2_data", 32'(ir_data), 32'hA001);
                chk("t2_pc", 32'(ir_pc), 32'h01);
            end
        end

        do_reset(1'b0);
        for (int c = 0; c <= 7; c++) begin
            if (c > 0) cyc();
            redirect = (c == 4);
            redirect_addr = 8'h40;
            #1;
            chk("t3_jmp", 32'(pc_jmp), 32'(c == 4));
            chk("t3_valid", 32'(ir_valid), 32'(c == 2 || c == 7));
            if (c == 4) begin
                chk("t3_addrin", 32'(pc_addrin), 32'h40);
                chk("t3_inc", 32'(pc_inc), 32'h0);
                chk("t3_en", 32'(imem_en), 32'h0);
            end
            if (c == 5) begin
                chk("t3_en5", 32'(imem_en), 32'h1);
                chk("t3_iaddr", 32'(imem_addr), 32'h40);
            end
            if (c == 7) begin
                chk("t3_data", 32'(ir_data), 32'hA040);
                chk("t3_pc", 32'(ir_pc), 32'h40);
            end
        end
        redirect = 1'b0;

        do_reset(1'b0);
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) cyc();
            redirect = (c == 2);
            redirect_addr = 8'h10;
            #1;
            chk("t4_jmp", 32'(pc_jmp), 32'(c == 2));
            chk("t4_valid", 32'(ir_valid), 32'(c == 5));
            if (c == 3) chk("t4_iaddr", 32'(imem_addr), 32'h10);
            if (c == 5) begin
                chk("t4_data", 32'(ir_data), 32'hA010);
                chk("t4_pc", 32'(ir_pc), 32'h10);
            end
        end
        redirect = 1'b0;

        do_reset(1'b0);
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) cyc();
            redirect = (c == 0);
            redirect_addr = 8'hFF;
            #1;
            chk("t5_valid", 32'(ir_valid), 32'(c == 3 || c == 6 || c == 9));
            if (c == 3 || c == 6 || c == 9) begin
                chk("t5_pc", 32'(ir_pc), 32'(wrap_pc[c / 3 - 1]));
                chk("t5_data", 32'(ir_data), 32'hA000 + 32'(wrap_pc[c / 3 - 1]));
            end
        end
        redirect = 1'b0;

        do_reset(1'b1);
        for (int c = 0; c <= 16; c++) begin
            if (c > 0) cyc();
            halt = (c < 10);
            redirect = (c == 5);
            redirect_addr = 8'h20;
            ir_ready = (c != 12 && c != 13);
            rst = (c == 13);
            #1;
            if (c < 10) begin
                chk("t6_halt_en", 32'(imem_en), 32'h0);
                chk("t6_halt_inc", 32'(pc_inc), 32'h0);
            end
            if (c == 5) chk("t6_halt_jmp", 32'(pc_jmp), 32'h1);
            if (c == 10 || c == 14) begin
                chk("t6_en", 32'(imem_en), 32'h1);
                chk("t6_iaddr", 32'(imem_addr), c == 10 ? 32'h20 : 32'h00);
            end
            if (c == 12) begin
                chk("t6_valid12", 32'(ir_valid), 32'h1);
                chk("t6_pc12", 32'(ir_pc), 32'h20);
                chk("t6_data12", 32'(ir_data), 32'hA020);
            end
            if (c == 14) chk("t6_rst_valid", 32'(ir_valid), 32'h0);
            if (c == 16) begin
                chk("t6_valid16", 32'(ir_valid), 32'h1);
                chk("t6_pc16", 32'(ir_pc), 32'h00);
                chk("t6_data16", 32'(ir_data), 32'hA000);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch sequencer sitting between the program counter and decode. It drives the `pc` block's `inc`/`jmp`/`addrin` controls and reads the synchronous instruction memory at the PC's `addrout`. It latches each returned word with its address into an instruction register and offers it to decode on a valid/ready handshake. Branch redirects from execute flush the in-flight fetch and reload the PC.

## Interface
Parameters:
- `AW`, 8: address width; must equal the `pc` block's address width.
- `IW`, 16: instruction word width.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; synchronous and active-high.
- `pc_addr`  in  AW  current PC value, from `pc.addrout`.
- `pc_inc`  out  AW-independent, 1  increment request to `pc.inc`.
- `pc_jmp`  out  1  load request to `pc.jmp`.
- `pc_addrin`  out  AW  load value to `pc.addrin`.
- `imem_en`  out  1  instruction memory read enable.
- `imem_addr`  out  AW  instruction memory read address.
- `imem_data`  in  IW  read data; valid exactly 1 cycle after an `imem_en` cycle.
- `halt`  in  1  when high, no new fetch is issued.
- `redirect`  in  1  single-cycle branch/jump request from execute.
- `redirect_addr`  in  AW  target address, valid with `redirect`.
- `ir_valid`  out  1  instruction register holds a deliverable instruction.
- `ir_data`  out  IW  instruction word.
- `ir_pc`  out  AW  address the instruction was fetched from.
- `ir_ready`  in  1  decode accepts the instruction this cycle.

## Operation
- FSM states: ISSUE, CAPTURE, HOLD. The reset state is ISSUE.
- ISSUE:
  - If `halt`=0 and `redirect`=0: `imem_en`=1, `imem_addr`=`pc_addr`, `pc_inc`=1; record `req_pc`<=`pc_addr`; next state CAPTURE.
  - Otherwise stay in ISSUE and assert neither `imem_en` nor `pc_inc`.
- CAPTURE:
  - If `redirect`=0: `ir_data`<=`imem_data`, `ir_pc`<=`req_pc`, valid flag<=1; next state HOLD.
- HOLD:
  - If the handshake completes (`ir_valid` & `ir_ready`): valid flag<=0; next state ISSUE.
  - Otherwise hold `ir_data`/`ir_pc` stable and stay in HOLD.
- `redirect`, in any state, has priority over all of the above:
  - Combinationally assert `pc_jmp`=1 and `pc_addrin`=`redirect_addr`, with `pc_inc`=0 and `imem_en`=0.
  - Clear the valid flag.
  - Discard any in-flight read; a redirect in CAPTURE means `imem_data` is not loaded.
  - Next state ISSUE. The PC holds the target on the following cycle.
- `ir_valid` = valid flag & ~`redirect`. A wrong-path instruction is never offered in a redirect cycle.
- `pc_inc` and `pc_jmp` are never high in the same cycle.
- `halt` is sampled only in ISSUE. A fetch already in CAPTURE/HOLD completes normally. `redirect` while halted still reloads the PC.
- Address wrap: the PC wraps from 0xFF to 0x00 by itself. This block treats 0xFF like any other address, and `ir_pc`=0xFF is captured exactly.
- Reset values:
  - `pc_inc`, `pc_jmp`, `imem_en`, `ir_valid`: 0.
  - `pc_addrin`, `imem_addr`, `ir_data`, `ir_pc`, `req_pc`: 0.
  - State: ISSUE.
- Reset mid-operation clears state and valid at the next edge and discards any pending read.
- All state is registered. The only combinational outputs are the ISSUE/redirect controls (`imem_en`, `imem_addr`, `pc_inc`, `pc_jmp`, `pc_addrin`) and the `ir_valid` gating.

## Timing
- Cycle 0 is the first cycle with `rst`=0 (PC=0x00). Instruction-register values below are visible during the cycle listed.
  - Cycle 0: `imem_en`=1, `imem_addr`=0x00, `pc_inc`=1.
  - Cycle 1: CAPTURE, `pc_addr`=0x01.
  - Cycle 2: `ir_valid`=1, `ir_data`=MEM[0x00], `ir_pc`=0x00.
- With `ir_ready` held high, the next ISSUE is at cycle 3, giving 1 instruction per 3 cycles. Each cycle `ir_ready` is low adds one cycle.
- Fetch latency is 2 cycles from ISSUE to `ir_valid`.
- A redirect at cycle n produces `imem_addr`=`redirect_addr` at cycle n+1, assuming `halt`=0, and `ir_valid` at n+3.
- `ir_data`/`ir_pc` change only on CAPTURE, when the state is CAPTURE and `redirect`=0.

## Test plan
- Reset release, MEM[i]=0xA000+i, `ir_ready`=1 → `ir_valid` at cycles 2, 5, 8 carrying (0xA000, 0x00), (0xA001, 0x01), (0xA002, 0x02); `pc_inc` high only at cycles 0, 3, 6.
- Backpressure: `ir_ready`=0 for cycles 2–6 → `ir_data`=0xA000 and `ir_pc`=0x00 stable; no `imem_en` or `pc_inc` until the cycle after `ir_ready` rises.
- Redirect to 0x40 during CAPTURE of 0x01 → that cycle `pc_jmp`=1, `pc_addrin`=0x40; MEM[0x01] is never delivered; next delivered instruction has `ir_pc`=0x40.
- Redirect to 0x10 in HOLD with `ir_ready`=1 in the same cycle → `ir_valid`=0 that cycle, no transfer; next delivered `ir_pc`=0x10.
- Redirect to 0xFF, then run → delivered `ir_pc` sequence 0xFF, 0x00, 0x01 (wrap).
- `halt`=1 from reset → no `imem_en` or `pc_inc` for 10 cycles; `rst` pulse while in HOLD → `ir_valid`=0 next cycle and fetch restarts at 0x00.
